// File: rtl/bresenham_line.sv
// bresenham_line: steps one line segment per go/done handshake into a valid/ready pixel stream.
// Optional feature macro BRES_CLIP_EN: off-frame points are skipped without being presented.
module bresenham_line #(
    parameter int OUT_WIDTH  = 8,
    parameter int FRAME_MIN  = 0,
    parameter int FRAME_MAX  = 255,
    parameter int BRES_WIDTH = OUT_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    input  logic signed [BRES_WIDTH-1:0] stax,
    input  logic signed [BRES_WIDTH-1:0] stay,
    input  logic signed [BRES_WIDTH-1:0] endx,
    input  logic signed [BRES_WIDTH-1:0] endy,
    output logic                         busy,
    output logic                         done,
    output logic                         plot,
    input  logic                         plot_ready,
    output logic [OUT_WIDTH-1:0]         x,
    output logic [OUT_WIDTH-1:0]         y
);
    localparam int W  = BRES_WIDTH + 1;
    localparam int EW = BRES_WIDTH + 2;
    localparam logic [1:0] IDLE = 2'd0, INIT = 2'd1, DRAW = 2'd2, DONE = 2'd3;
    localparam logic signed [W-1:0] FMIN = W'(FRAME_MIN);
    localparam logic signed [W-1:0] FMAX = W'(FRAME_MAX);
`ifdef BRES_CLIP_EN
    localparam logic CLIP = 1'b1;
`else
    localparam logic CLIP = 1'b0;
`endif

    logic [1:0]             state_q, state_d;
    logic signed [W-1:0]    x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic signed [W-1:0]    px_q, px_d, py_q, py_d, dx_q, dx_d, dy_q, dy_d, sx_q, sx_d, sy_q, sy_d;
    logic signed [EW-1:0]   err_q, err_d;
    logic                   busy_q, busy_d, done_q, done_d, plot_q, plot_d;
    logic [OUT_WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic signed [W-1:0]    ddx, ddy;
    logic signed [EW-1:0]   e2, dx_e, dy_e;
    logic                   adv, at_end, in_frame;

    assign busy = busy_q;
    assign done = done_q;
    assign plot = plot_q;
    assign x    = x_q;
    assign y    = y_q;

    // Next-state: latch endpoints, set up the stepper, step on consume (or on skip), derive registered outputs.
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        px_d    = px_q;
        py_d    = py_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        err_d   = err_q;
        ddx     = x1_q - x0_q;
        ddy     = y1_q - y0_q;
        dx_e    = {dx_q[W-1], dx_q};
        dy_e    = {dy_q[W-1], dy_q};
        e2      = err_q <<< 1;
        adv     = plot_ready || !plot_q;
        at_end  = (px_q == x1_q) && (py_q == y1_q);
        if (state_q == IDLE && go) begin
            state_d = INIT;
            x0_d    = {stax[BRES_WIDTH-1], stax};
            y0_d    = {stay[BRES_WIDTH-1], stay};
            x1_d    = {endx[BRES_WIDTH-1], endx};
            y1_d    = {endy[BRES_WIDTH-1], endy};
        end else if (state_q == INIT) begin
            state_d = DRAW;
            dx_d    = ddx[W-1] ? -ddx : ddx;
            dy_d    = ddy[W-1] ? ddy : -ddy;
            sx_d    = ddx[W-1] ? {W{1'b1}} : W'(1);
            sy_d    = ddy[W-1] ? {W{1'b1}} : W'(1);
            err_d   = {dx_d[W-1], dx_d} + {dy_d[W-1], dy_d};
            px_d    = x0_q;
            py_d    = y0_q;
        end else if (state_q == DRAW && adv) begin
            if (at_end) begin
                state_d = DONE;
            end else begin
                if (e2 >= dy_e) begin
                    err_d = err_d + dy_e;
                    px_d  = px_q + sx_q;
                end
                if (e2 <= dx_e) begin
                    err_d = err_d + dx_e;
                    py_d  = py_q + sy_q;
                end
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        in_frame = px_d >= FMIN && px_d <= FMAX && py_d >= FMIN && py_d <= FMAX;
        busy_d   = state_d == INIT || state_d == DRAW;
        done_d   = state_d == DONE;
        plot_d   = state_d == DRAW && (!CLIP || in_frame);
        x_d      = px_d[OUT_WIDTH-1:0];
        y_d      = py_d[OUT_WIDTH-1:0];
    end

    // State and output registers with synchronous reset that aborts any line in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            px_q    <= px_d;
            py_q    <= py_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            plot_q  <= plot_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end
endmodule

// File: doc/bresenham_line.md
# bresenham_line

Line-drawing engine that accepts one line segment per `go`/`done` handshake from the vector fetch FSM and steps it out pixel by pixel using integer Bresenham arithmetic. Endpoints arrive as signed `BRES_WIDTH` values (unsigned frame coordinates zero-extended by one bit). Each point is emitted on a valid/ready pixel stream toward the DAC/frame output stage. It is the responder side of the `go`/`busy`/`done` line interface.

## Interface
- `OUT_WIDTH`, 8, width of emitted pixel coordinates
- `FRAME_MIN`, 0, lowest visible coordinate (signed compare)
- `FRAME_MAX`, 255, highest visible coordinate (signed compare)
- `BRES_WIDTH`, OUT_WIDTH+1, signed endpoint width
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `go`  in  1  start strobe; sampled only in IDLE
- `stax`, `stay`  in  BRES_WIDTH (signed)  start point
- `endx`, `endy`  in  BRES_WIDTH (signed)  end point
- `busy`  out  1  high while a line is being set up or drawn
- `done`  out  1  one-cycle pulse after the last point is handled
- `plot`  out  1  pixel valid
- `plot_ready`  in  1  downstream accepts pixel
- `x`, `y`  out  OUT_WIDTH  current pixel, low OUT_WIDTH bits of internal position

## Operation
- States: IDLE, INIT, DRAW, DONE. All outputs registered.
- IDLE: busy=0, plot=0, done=0. On `go=1`, latch all four endpoints and go to INIT. `go` is ignored in every other state.
- INIT: busy=1. Compute `dx=|endx-stax|`, `dy=-|endy-stay|`, `sx=+1/-1` by sign of `endx-stax` (+1 if equal), `sy` likewise, `err=dx+dy`. Set pos=(stax,stay). Go to DRAW.
- Widths: dx/dy/sx/sy/pos are BRES_WIDTH+1 signed; err and `e2=2*err` are BRES_WIDTH+2 signed. No overflow is possible for any legal input.
- DRAW: busy=1, plot=1, x/y=pos[OUT_WIDTH-1:0].
  - The point is consumed on a cycle with plot && plot_ready.
  - On consume, if pos==(endx,endy), go to DONE.
  - Otherwise step with e2 from the current err. If e2>=dy: err+=dy, px+=sx. If e2<=dx: err+=dx, py+=sy. Both updates apply in the same cycle when both hold.
  - While plot_ready=0, pos, err, x, y and plot hold stable.
- DONE: busy=0, plot=0, done=1 for exactly one cycle, then IDLE.
- Point count per line = max(dx,|dy|)+1. A degenerate line (start==end) emits exactly one point.
- Reset, including mid-line: next state IDLE, busy=0, done=0, plot=0, x=0, y=0, err=0. No done pulse for an aborted line.

## Timing
- `go` sampled high at edge 0: busy=1 from edge 1 (INIT), first plot=1 from edge 2.
- With plot_ready tied high: one point per cycle. For N points, last point at edge N+1, done=1 and busy=0 at edge N+2, IDLE at edge N+3.
- A new `go` is accepted at the earliest in the cycle after done (the IDLE cycle).
- busy and done are never high together.

## Configuration
- `BRES_CLIP_EN` defined:
  - A point with px or py outside [FRAME_MIN, FRAME_MAX] is not presented: plot=0 and the stepper advances in one cycle without waiting for plot_ready.
  - If the end point itself is off-frame, DONE follows its skip cycle.
- `BRES_CLIP_EN` undefined: every point is presented, with x/y wrapping to the low OUT_WIDTH bits.

## Test plan
- Horizontal line (0,0)->(5,0), ready=1 -> six points x=0..5, y=0 on edges 2..7; done pulse on edge 8; busy high on edges 1..7.
- Steep line (10,10)->(7,20) -> 11 points; y increments on every point; x decrements exactly 3 times; last point (7,20); one done pulse.
- Single point (3,3)->(3,3) -> one plot (3,3), then done on the next cycle.
- Backpressure on (0,0)->(3,3): hold plot_ready=0 for 4 cycles on the second point -> (1,1) held stable with plot=1; sequence (0,0),(1,1),(2,2),(3,3) with none skipped or repeated.
- Clip on (-3,0)->(2,0) with BRES_CLIP_EN defined -> only x=0,1,2 plotted; the 3 off-frame points are skipped in 3 cycles with plot=0; done follows. Without the macro -> 6 points, x=253,254,255,0,1,2.
- Assert rst during DRAW of (0,0)->(100,0) -> next cycle busy=0, plot=0, x=y=0, no done pulse; a following `go` draws a fresh line correctly. Also raise `go` during DRAW -> ignored.
